lfsr_gen: RTL and testbench

Parametrised linear-feedback shift register generalising the team's fixed 5-bit LFSR. It supports configurable width and tap mask, Fibonacci or Galois feedback, step enable, and runtime seed loading with all-zero lock-up protection. It also reports step count and period wrap. It serves as the pseudo-random source for scramblers, test-pattern generators and randomised delays elsewhere in the design.

---
 rtl/lfsr_gen.sv | 77 +++++++
 tb/tb_lfsr_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with Fibonacci/Galois feedback, seed loading with zero-lock
// protection, step counter and period-wrap / lock-up pulses.
module lfsr_gen #(
  parameter int               WIDTH      = 5,
  parameter bit               MODE       = 1'b0,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(5'b10100),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // value the current period started from; a step landing here closes the period
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] nxt;

  generate
    if (MODE == 1'b0) begin : g_fib
      assign nxt = {q[WIDTH-2:0], ^(q & TAPS)};
    end else begin : g_gal
      assign nxt = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= RESET_SEED;
      start  <= RESET_SEED;
      count  <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (load) begin
      count <= '0;
      wrap  <= 1'b0;
      if (seed == '0) begin
        q      <= ONE;
        start  <= ONE;
        lockup <= 1'b1;
      end else begin
        q      <= seed;
        start  <= seed;
        lockup <= 1'b0;
      end
    end else if (en) begin
      // a zero next state only arises from degenerate taps; restart the period
      if (nxt == '0) begin
        q      <= start;
        count  <= '0;
        wrap   <= 1'b0;
        lockup <= 1'b1;
      end else if (nxt == start) begin
        q      <= nxt;
        count  <= '0;
        wrap   <= 1'b1;
        lockup <= 1'b0;
      end else begin
        q      <= nxt;
        count  <= count + ONE;
        wrap   <= 1'b0;
        lockup <= 1'b0;
      end
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Fibonacci, Galois, degenerate-tap and 8-bit
// instances driven from shared controls, checked against hand-computed values.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset, en, load;
  logic [4:0] seed5;
  logic [7:0] seed8;

  logic [4:0] q_f, c_f, q_g, c_g, q_d, c_d;
  logic       w_f, l_f, w_g, l_g, w_d, l_d;
  logic [7:0] q_8, c_8;
  logic       w_8, l_8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(5), .MODE(1'b0), .TAPS(5'b10100), .RESET_SEED(5'd1)) u_fib (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed5),
    .q(q_f), .count(c_f), .wrap(w_f), .lockup(l_f));

  lfsr_gen #(.WIDTH(5), .MODE(1'b1), .TAPS(5'b01001), .RESET_SEED(5'd1)) u_gal (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed5),
    .q(q_g), .count(c_g), .wrap(w_g), .lockup(l_g));

  lfsr_gen #(.WIDTH(5), .MODE(1'b0), .TAPS(5'b00000), .RESET_SEED(5'd1)) u_deg (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed5),
    .q(q_d), .count(c_d), .wrap(w_d), .lockup(l_d));

  lfsr_gen #(.WIDTH(8), .MODE(1'b0), .TAPS(8'b10111000), .RESET_SEED(8'd1)) u_w8 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed8),
    .q(q_8), .count(c_8), .wrap(w_8), .lockup(l_8));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] fib_exp [1:5];
  logic [4:0] gal_exp [1:5];
  logic [31:0] seen;
  bit dup;
  int fw_f, nw_f, nl_f, fw_g, nw_g, fw_8, nw_8, fw_l;

  initial begin
    fib_exp[1] = 5'b00010; fib_exp[2] = 5'b00100; fib_exp[3] = 5'b01001;
    fib_exp[4] = 5'b10010; fib_exp[5] = 5'b00101;
    gal_exp[1] = 5'b00010; gal_exp[2] = 5'b00100; gal_exp[3] = 5'b01000;
    gal_exp[4] = 5'b10000; gal_exp[5] = 5'b01001;

    reset = 1'b1; en = 1'b0; load = 1'b0; seed5 = '0; seed8 = '0;
    step(); step();
    chk("rst_q", q_f, 5'b00001);
    chk("rst_count", c_f, 5'd0);
    chk("rst_wrap", w_f, 1'b0);
    chk("rst_lockup", l_f, 1'b0);
    chk("rst_q8", q_8, 8'd1);

    // free run from reset: sequence, period, wrap and degenerate lock-up
    reset = 1'b0; en = 1'b1;
    seen = 32'h2; dup = 1'b0;
    fw_f = 0; nw_f = 0; nl_f = 0; fw_g = 0; nw_g = 0; fw_8 = 0; nw_8 = 0;
    for (int s = 1; s <= 255; s++) begin
      step();
      if (s <= 5) begin
        chk($sformatf("fib_q_s%0d", s), q_f, fib_exp[s]);
        chk($sformatf("fib_cnt_s%0d", s), c_f, 5'(s));
        chk($sformatf("gal_q_s%0d", s), q_g, gal_exp[s]);
      end
      if (s < 31) begin
        if (seen[q_f]) dup = 1'b1;
        seen[q_f] = 1'b1;
      end
      if (w_f) begin nw_f++; if (fw_f == 0) fw_f = s; end
      if (l_f) nl_f++;
      if (w_g) begin nw_g++; if (fw_g == 0) fw_g = s; end
      if (w_8) begin nw_8++; if (fw_8 == 0) fw_8 = s; end
      if (s == 30) chk("fib_cnt_max", c_f, 5'd30);
      if (s == 31) begin
        chk("fib_wrap_q", q_f, 5'b00001);
        chk("fib_wrap_cnt", c_f, 5'd0);
        chk("fib_wrap_pulse", w_f, 1'b1);
      end
      if (s == 4) begin
        chk("deg_q_s4", q_d, 5'b10000);
        chk("deg_lk_s4", l_d, 1'b0);
      end
      if (s == 5) begin
        chk("deg_q_s5", q_d, 5'b00001);
        chk("deg_cnt_s5", c_d, 5'd0);
        chk("deg_lk_s5", l_d, 1'b1);
        chk("deg_wrap_s5", w_d, 1'b0);
      end
      if (s == 6) begin
        chk("deg_q_s6", q_d, 5'b00010);
        chk("deg_lk_s6", l_d, 1'b0);
      end
      if (s == 255) begin
        chk("w8_wrap_q", q_8, 8'd1);
        chk("w8_wrap_cnt", c_8, 8'd0);
      end
    end
    chk("fib_no_dup", dup, 1'b0);
    chk("fib_first_wrap", fw_f, 31);
    chk("fib_wrap_total", nw_f, 8);
    chk("fib_no_lockup", nl_f, 0);
    chk("gal_first_wrap", fw_g, 31);
    chk("gal_wrap_total", nw_g, 8);
    chk("w8_first_wrap", fw_8, 255);
    chk("w8_wrap_total", nw_8, 1);
    // 255 = 8*31 + 7 steps into the current period
    chk("fib_q_after255", q_f, 5'b10110);
    chk("fib_cnt_after255", c_f, 5'd7);

    // hold
    en = 1'b0;
    for (int h = 1; h <= 3; h++) begin
      step();
      chk($sformatf("hold_q_%0d", h), q_f, 5'b10110);
      chk($sformatf("hold_cnt_%0d", h), c_f, 5'd7);
      chk($sformatf("hold_wrap_%0d", h), w_f, 1'b0);
    end

    // load beats en; a step would have given 01100 / count 8
    en = 1'b1; load = 1'b1; seed5 = 5'b10110;
    step();
    chk("load_q", q_f, 5'b10110);
    chk("load_cnt", c_f, 5'd0);
    chk("load_lockup", l_f, 1'b0);
    load = 1'b0;
    fw_l = 0;
    for (int s = 1; s <= 31; s++) begin
      step();
      if (w_f && fw_l == 0) fw_l = s;
      if (s == 30) chk("load_cnt_max", c_f, 5'd30);
    end
    chk("load_first_wrap", fw_l, 31);
    chk("load_wrap_q", q_f, 5'b10110);
    chk("load_wrap_cnt", c_f, 5'd0);

    // zero seed is rejected
    en = 1'b0; load = 1'b1; seed5 = 5'b00000;
    step();
    chk("zseed_q", q_f, 5'b00001);
    chk("zseed_cnt", c_f, 5'd0);
    chk("zseed_lockup", l_f, 1'b1);
    chk("zseed_wrap", w_f, 1'b0);
    load = 1'b0;
    step();
    chk("zseed_lockup_clr", l_f, 1'b0);
    chk("zseed_q_hold", q_f, 5'b00001);

    // mid-run reset at count 7
    en = 1'b1;
    repeat (7) step();
    chk("pre_rst_q", q_f, 5'b10110);
    chk("pre_rst_cnt", c_f, 5'd7);
    reset = 1'b1;
    step();
    chk("mid_rst_q", q_f, 5'b00001);
    chk("mid_rst_cnt", c_f, 5'd0);
    load = 1'b1; seed5 = 5'b10110;
    step();
    chk("rst_hold_q", q_f, 5'b00001);
    chk("rst_hold_cnt", c_f, 5'd0);
    chk("rst_hold_lockup", l_f, 1'b0);
    reset = 1'b0; load = 1'b0;
    step();
    chk("post_rst_q", q_f, 5'b00010);
    chk("post_rst_cnt", c_f, 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
